// File: rtl/rtc_bus_burst_master.sv
// Multiplexed-bus burst master for the RTC chip, programmed through the PicoBlaze port window.
// Optional build macro RTC_BURST_AUTOINC_EN: when defined, the bus address advances by one after each beat.
//   state   | meaning
//   IDLE    | waiting for a start command
//   ADDR    | address phase, cs low, address driven
//   GAP_A   | strobes released between address and data
//   DATA    | data phase, wr or rd low
//   GAP_D   | strobes released after data, next beat or finish
//   DONE    | one-cycle completion pulse
module rtc_bus_burst_master #(
  parameter int          DATA_W       = 8,
  parameter int          PHASE_CYCLES = 4,
  parameter int          BURST_MAX    = 8,
  parameter logic [7:0]  BASE_PORT    = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        port_id,
  input  logic [DATA_W-1:0] in_dato,
  input  logic              write_strobe,
  input  logic              read_strobe,
  output logic [DATA_W-1:0] out_dato,
  output logic              reg_a_d,
  output logic              reg_cs,
  output logic              reg_rd,
  output logic              reg_wr,
  output logic [DATA_W-1:0] bus_o,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_i,
  output logic              busy,
  output logic              fin_lectura_escritura
);

  localparam int AW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] PH_LOAD = CW'(PHASE_CYCLES - 1);
  localparam logic [AW:0]   LEN_MAX = (AW+1)'(BURST_MAX);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);

  localparam logic [7:0] PORT_ADDR = BASE_PORT;
  localparam logic [7:0] PORT_PUSH = BASE_PORT + 8'd1;
  localparam logic [7:0] PORT_LEN  = BASE_PORT + 8'd2;
  localparam logic [7:0] PORT_CMD  = BASE_PORT + 8'd3;
  localparam logic [7:0] PORT_DATA = BASE_PORT + 8'd4;
  localparam logic [7:0] PORT_STAT = BASE_PORT + 8'd5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_GAP_A = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_GAP_D = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state;
  logic [CW-1:0]     phase_cnt;
  logic [AW:0]       beats_left;
  logic [DATA_W-1:0] cur_addr;
  logic              is_write;
  logic [DATA_W-1:0] addr_q;
  logic [AW:0]       len_q;
  logic              err_q;

  logic [DATA_W-1:0] wmem [BURST_MAX];
  logic [AW-1:0]     wbuf_wp, wbuf_rp;
  logic [AW:0]       wbuf_cnt;
  logic [DATA_W-1:0] rmem [BURST_MAX];
  logic [AW-1:0]     rbuf_wp, rbuf_rp;
  logic [AW:0]       rbuf_cnt;

  logic wr_addr, wr_push, wr_len, wr_cmd, rd_pop, rd_stat;
  logic cmd_ok, cmd_err, phase_end, data_last, last_beat;
  logic wbuf_empty, wbuf_full, rbuf_empty, rbuf_full;
  logic wbuf_push, wbuf_pop, wbuf_flush, rbuf_push, rbuf_pop, rbuf_flush;
  logic push_err, pop_err, wbeat_err;

  assign wr_addr = write_strobe && (port_id == PORT_ADDR);
  assign wr_push = write_strobe && (port_id == PORT_PUSH);
  assign wr_len  = write_strobe && (port_id == PORT_LEN);
  assign wr_cmd  = write_strobe && (port_id == PORT_CMD);
  assign rd_pop  = read_strobe  && (port_id == PORT_DATA);
  assign rd_stat = read_strobe  && (port_id == PORT_STAT);

  assign busy      = (state == S_ADDR) || (state == S_GAP_A) ||
                     (state == S_DATA) || (state == S_GAP_D);
  assign cmd_ok    = wr_cmd && !busy;
  assign cmd_err   = wr_cmd && busy;
  assign phase_end = (phase_cnt == '0);
  assign data_last = (state == S_DATA) && phase_end;
  assign last_beat = (beats_left == LEN_ONE);

  assign wbuf_empty = (wbuf_cnt == '0);
  assign wbuf_full  = (wbuf_cnt == LEN_MAX);
  assign rbuf_empty = (rbuf_cnt == '0);
  assign rbuf_full  = (rbuf_cnt == LEN_MAX);

  assign wbuf_push  = wr_push && !wbuf_full;
  assign push_err   = wr_push && wbuf_full;
  assign wbuf_pop   = data_last && is_write && !wbuf_empty;
  assign wbeat_err  = data_last && is_write && wbuf_empty;
  assign wbuf_flush = (state == S_GAP_D) && last_beat && is_write;
  assign rbuf_push  = data_last && !is_write && !rbuf_full;
  assign rbuf_pop   = rd_pop && !rbuf_empty;
  assign pop_err    = rd_pop && rbuf_empty;
  assign rbuf_flush = cmd_ok && !in_dato[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      phase_cnt  <= '0;
      beats_left <= '0;
      cur_addr   <= '0;
      is_write   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (cmd_ok) begin
            state      <= S_ADDR;
            phase_cnt  <= PH_LOAD;
            beats_left <= len_q;
            cur_addr   <= addr_q;
            is_write   <= in_dato[0];
          end else begin
            state <= S_IDLE;
          end
        end
        S_ADDR: begin
          if (phase_end) state <= S_GAP_A;
          else           phase_cnt <= phase_cnt - CW'(1);
        end
        S_GAP_A: begin
          state     <= S_DATA;
          phase_cnt <= PH_LOAD;
        end
        S_DATA: begin
          if (phase_end) state <= S_GAP_D;
          else           phase_cnt <= phase_cnt - CW'(1);
        end
        S_GAP_D: begin
          beats_left <= beats_left - LEN_ONE;
          phase_cnt  <= PH_LOAD;
`ifdef RTC_BURST_AUTOINC_EN
          cur_addr   <= cur_addr + DATA_W'(1);
`else
          cur_addr   <= cur_addr;
`endif
          state      <= last_beat ? S_DONE : S_ADDR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Configuration registers; length is clamped to 1..BURST_MAX on write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      len_q  <= LEN_ONE;
    end else begin
      if (wr_addr) addr_q <= in_dato;
      if (wr_len) begin
        if (in_dato == '0)                      len_q <= LEN_ONE;
        else if (in_dato > DATA_W'(BURST_MAX))  len_q <= LEN_MAX;
        else                                    len_q <= in_dato[AW:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         err_q <= 1'b0;
    else if (cmd_err || push_err || pop_err || wbeat_err) err_q <= 1'b1;
    else if (rd_stat)                                  err_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wbuf_push) wmem[wbuf_wp] <= in_dato;
    if (rbuf_push) rmem[rbuf_wp] <= bus_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbuf_wp  <= '0;
      wbuf_rp  <= '0;
      wbuf_cnt <= '0;
    end else if (wbuf_flush) begin
      wbuf_wp  <= '0;
      wbuf_rp  <= '0;
      wbuf_cnt <= '0;
    end else begin
      if (wbuf_push) wbuf_wp <= wbuf_wp + AW'(1);
      if (wbuf_pop)  wbuf_rp <= wbuf_rp + AW'(1);
      wbuf_cnt <= wbuf_cnt + (AW+1)'(wbuf_push) - (AW+1)'(wbuf_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rbuf_wp  <= '0;
      rbuf_rp  <= '0;
      rbuf_cnt <= '0;
    end else if (rbuf_flush) begin
      rbuf_wp  <= '0;
      rbuf_rp  <= '0;
      rbuf_cnt <= '0;
    end else begin
      if (rbuf_push) rbuf_wp <= rbuf_wp + AW'(1);
      if (rbuf_pop)  rbuf_rp <= rbuf_rp + AW'(1);
      rbuf_cnt <= rbuf_cnt + (AW+1)'(rbuf_push) - (AW+1)'(rbuf_pop);
    end
  end

  // Pads decode straight from state so reset releases them without waiting for a clock
  always_comb begin
    reg_cs  = 1'b1;
    reg_rd  = 1'b1;
    reg_wr  = 1'b1;
    reg_a_d = 1'b1;
    bus_oe  = 1'b0;
    bus_o   = '0;
    case (state)
      S_ADDR: begin
        reg_cs  = 1'b0;
        reg_a_d = 1'b0;
        bus_oe  = 1'b1;
        bus_o   = cur_addr;
      end
      S_DATA: begin
        reg_cs = 1'b0;
        if (is_write) begin
          reg_wr = 1'b0;
          bus_oe = 1'b1;
          bus_o  = wbuf_empty ? '0 : wmem[wbuf_rp];
        end else begin
          reg_rd = 1'b0;
        end
      end
      S_GAP_D: reg_a_d = last_beat;
      default: ;
    endcase
  end

  assign fin_lectura_escritura = (state == S_DONE);

  always_comb begin
    out_dato = '0;
    if (port_id == PORT_DATA)
      out_dato = rbuf_empty ? '0 : rmem[rbuf_rp];
    else if (port_id == PORT_STAT)
      out_dato = DATA_W'({err_q, rbuf_empty, wbuf_full, busy});
  end

endmodule

// File: tb/tb_rtc_bus_burst_master.sv
// Self-checking bench for rtc_bus_burst_master: directed sequence with random data and
// addresses, compared against a per-cycle bus-shape model and queue models of both buffers.
module tb_rtc_bus_burst_master;

  localparam int         P    = 4;
  localparam int         BM   = 8;
  localparam int         BEAT = 2 * P + 2;
  localparam logic [7:0] BASE = 8'h20;
`ifdef RTC_BURST_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_id = BASE + 8'd5;
  logic [7:0] in_dato = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] out_dato;
  logic       reg_a_d, reg_cs, reg_rd, reg_wr;
  logic [7:0] bus_o;
  logic       bus_oe;
  logic [7:0] bus_i = 8'h00;
  logic       busy;
  logic       fin;

  rtc_bus_burst_master #(
    .DATA_W(8), .PHASE_CYCLES(P), .BURST_MAX(BM), .BASE_PORT(BASE)
  ) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .in_dato(in_dato),
    .write_strobe(write_strobe), .read_strobe(read_strobe), .out_dato(out_dato),
    .reg_a_d(reg_a_d), .reg_cs(reg_cs), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .bus_o(bus_o), .bus_oe(bus_oe), .bus_i(bus_i), .busy(busy),
    .fin_lectura_escritura(fin)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cur_k  = 0;

  logic [7:0] wq[$];
  logic [7:0] rq[$];
  bit         exp_err = 1'b0;
  int         exp_len = 1;
  logic [7:0] exp_start = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cur_k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_port(input logic [7:0] p, input logic [7:0] d);
    port_id = p;
    in_dato = d;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    port_id = BASE + 8'd5;
  endtask

  task automatic set_addr(input logic [7:0] a);
    exp_start = a;
    wr_port(BASE, a);
  endtask

  task automatic set_len(input int v);
    exp_len = (v == 0) ? 1 : ((v > BM) ? BM : v);
    wr_port(BASE + 8'd2, 8'(v));
  endtask

  task automatic push(input logic [7:0] d);
    if (wq.size() < BM) wq.push_back(d);
    else exp_err = 1'b1;
    wr_port(BASE + 8'd1, d);
  endtask

  task automatic pop();
    logic [7:0] e;
    if (rq.size() > 0) e = rq.pop_front();
    else begin
      e = 8'h00;
      exp_err = 1'b1;
    end
    port_id = BASE + 8'd4;
    #1;
    check("pop_data", out_dato, e);
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    port_id = BASE + 8'd5;
  endtask

  task automatic check_status(input string tag);
    port_id = BASE + 8'd5;
    #1;
    check(tag, out_dato, {4'b0, exp_err, rq.size() == 0, wq.size() == BM, 1'b0});
  endtask

  task automatic clear_err();
    port_id = BASE + 8'd5;
    read_strobe = 1'b1;
    #1;
    check("stat_before_clear", out_dato, {4'b0, exp_err, rq.size() == 0, wq.size() == BM, 1'b0});
    tick();
    read_strobe = 1'b0;
    exp_err = 1'b0;
  endtask

  // Issue a command and follow the whole burst cycle by cycle from T+1 to the idle cycle after DONE.
  task automatic run_burst(input bit w, input logic [7:0] key, input int inject_k);
    int n;
    int b, o;
    bit in_a, in_d;
    logic [7:0] ea;
    logic [7:0] wexp [BM];
    n = exp_len;
    if (!w) rq.delete();
    for (int i = 0; i < BM; i++) wexp[i] = (i < wq.size()) ? wq[i] : 8'h00;
    if (w && n > wq.size()) exp_err = 1'b1;
    wr_port(BASE + 8'd3, {7'b0, w});
    for (int k = 1; k <= n * BEAT + 1; k++) begin
      cur_k = k;
      if (k <= n * BEAT) begin
        b = (k - 1) / BEAT;
        o = (k - 1) % BEAT;
        ea = AUTOINC ? exp_start + 8'(b) : exp_start;
        in_a = (o < P);
        in_d = (o > P) && (o <= 2 * P);
        bus_i = (in_d && o == 2 * P) ? (ea ^ key) : 8'($urandom);
        if (k == inject_k) begin
          port_id = BASE + 8'd3;
          in_dato = 8'h01;
          write_strobe = 1'b1;
          exp_err = 1'b1;
        end
        #1;
        check("cs", reg_cs, !(in_a || in_d));
        check("wr", reg_wr, !(in_d && w));
        check("rd", reg_rd, !(in_d && !w));
        check("oe", bus_oe, in_a || (in_d && w));
        check("busy", busy, 1);
        check("fin_early", fin, 0);
        if (in_a) begin
          check("a_d_addr", reg_a_d, 0);
          check("bus_addr", bus_o, ea);
        end
        if (in_d) begin
          check("a_d_data", reg_a_d, 1);
          if (w) check("bus_wdata", bus_o, wexp[b]);
        end
        if (k != inject_k) check("stat_busy", out_dato[0], 1);
        if (!w && in_d && o == 2 * P) rq.push_back(ea ^ key);
      end else begin
        #1;
        check("fin_done", fin, 1);
        check("busy_done", busy, 0);
        check("cs_done", reg_cs, 1);
        check("oe_done", bus_oe, 0);
      end
      tick();
      write_strobe = 1'b0;
      port_id = BASE + 8'd5;
    end
    cur_k = n * BEAT + 2;
    check("fin_after", fin, 0);
    check("busy_after", busy, 0);
    check("cs_after", reg_cs, 1);
    if (w) wq.delete();
  endtask

  initial begin
    logic [7:0] a;
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs", reg_cs, 1);
    check("rst_rd", reg_rd, 1);
    check("rst_wr", reg_wr, 1);
    check("rst_a_d", reg_a_d, 1);
    check("rst_oe", bus_oe, 0);
    check("rst_bus_o", bus_o, 0);
    check("rst_busy", busy, 0);
    check("rst_fin", fin, 0);
    reset = 1'b0;
    tick();
    check_status("rst_status");
    port_id = BASE + 8'd6;
    #1;
    check("unmapped_port", out_dato, 0);

    // Single write beat
    set_addr(8'h21);
    push(8'h5A);
    set_len(1);
    run_burst(1'b1, 8'h00, 0);
    check_status("stat_after_write1");

    // Random three-beat write
    a = 8'($urandom);
    set_addr(a);
    for (int i = 0; i < 3; i++) push(8'($urandom));
    set_len(3);
    run_burst(1'b1, 8'h00, 0);
    check_status("stat_after_write3");

    // Read burst wrapping FE, FF, 00
    set_addr(8'hFE);
    set_len(3);
    run_burst(1'b0, 8'hFF, 0);
    for (int i = 0; i < 3; i++) pop();
    check_status("stat_after_read3");

    // Four-beat read at 0C
    set_addr(8'h0C);
    set_len(4);
    run_burst(1'b0, 8'($urandom), 0);
    for (int i = 0; i < 4; i++) pop();

    // Command while busy is ignored and flags err
    set_addr(8'($urandom));
    set_len(2);
    run_burst(1'b0, 8'($urandom), 5);
    check_status("stat_busy_err");
    clear_err();
    check_status("stat_err_cleared");
    pop();
    pop();

    // Length 0 clamps to 1; extra pop hits an empty buffer
    set_addr(8'($urandom));
    set_len(0);
    run_burst(1'b0, 8'($urandom), 0);
    pop();
    pop();
    check_status("stat_pop_empty");
    clear_err();

    // Overfill the write buffer, then drain it with an oversize length
    for (int i = 0; i < BM; i++) push(8'($urandom));
    check_status("stat_wr_full");
    push(8'hEE);
    check_status("stat_push_full");
    clear_err();
    set_addr(8'($urandom));
    set_len(200);
    run_burst(1'b1, 8'h00, 0);
    check_status("stat_after_write8");

    // Write beats with nothing buffered
    n = 2;
    set_len(n);
    run_burst(1'b1, 8'h00, 0);
    check_status("stat_wbeat_empty");
    clear_err();

    // Reset in the second DATA cycle of a write
    push(8'hC3);
    set_len(1);
    wr_port(BASE + 8'd3, 8'h01);
    for (int k = 1; k < P + 3; k++) tick();
    cur_k = P + 3;
    check("wr_mid_data", reg_wr, 0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_cs", reg_cs, 1);
    check("mid_rst_wr", reg_wr, 1);
    check("mid_rst_rd", reg_rd, 1);
    check("mid_rst_oe", bus_oe, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fin", fin, 0);
    wq.delete();
    rq.delete();
    exp_err = 1'b0;
    exp_len = 1;
    exp_start = 8'h00;
    @(posedge clk);
    #3;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("no_fin_after_rst", fin, 0);
    end
    check_status("stat_after_mid_rst");

    // Defaults after reset: one beat at address 0
    run_burst(1'b0, 8'($urandom), 0);
    pop();
    check_status("stat_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
